// File: rtl/sniffer_pkg.sv
// Shared types and defaults for the sniffer packet-match controller.
// Holds the controller state encoding and the score-width helper.
package sniffer_pkg;

    typedef enum logic [2:0] {
        RESET,
        LOAD_CFG,
        IDLE,
        COMPARE,
        DRAIN,
        EVALUATE,
        STORE,
        ERROR
    } ctrl_state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 64;
    localparam int DEF_WEIGHT_W    = 4;
    localparam int DEF_WAIT_CYCLES = 4;
    localparam int DEF_ERR_W       = 6;
    localparam int DEF_EMPTY_W     = 2;
    localparam int DRAIN_W         = 4;

    // Wide enough to hold the sum of every channel weight at full scale.
    function automatic int sum_w(input int num_ch, input int weight_w);
        return weight_w + $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/match_controller_n_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency 1 cycle; no backpressure, holds at all-ones once saturated.
module sat_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/match_controller_n.sv
// Packet-match controller: sequences packets, drains comparators, scores and stores.
// Outputs registered from next_state; ready drops outside IDLE/COMPARE/ERROR to hold off beats.
module match_controller_n
    import sniffer_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WEIGHT_W    = DEF_WEIGHT_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int EMPTY_W     = DEF_EMPTY_W
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic                                  update_done,
    input  logic                                  sop,
    input  logic                                  eop,
    input  logic                                  valid,
    input  logic [ERR_W-1:0]                      error,
    input  logic [EMPTY_W-1:0]                    empty,
    input  logic [NUM_CH-1:0]                     match,
    input  logic [NUM_CH*WEIGHT_W-1:0]            weights,
    input  logic [sum_w(NUM_CH, WEIGHT_W)-1:0]    threshold,
    input  logic                                  counter_clear,
    output logic                                  ready,
    output logic                                  inc_addr,
    output logic                                  clear,
    output logic [NUM_CH*CNT_W-1:0]               hits,
    output logic [CNT_W-1:0]                      pkt_count,
    output logic [CNT_W-1:0]                      err_count,
    output logic [sum_w(NUM_CH, WEIGHT_W)-1:0]    score
);

    localparam int SUM_W = sum_w(NUM_CH, WEIGHT_W);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(WAIT_CYCLES - 1);

    ctrl_state_t        state;
    ctrl_state_t        next_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [SUM_W-1:0]   sum_c;
    logic               err_inc;
    logic               pkt_inc;
    logic               bad_beat;

    assign bad_beat = (error != '0);
    assign pkt_inc  = (state == EVALUATE);

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (match[i]) begin
                sum_c = sum_c + SUM_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
            end
        end
    end

    always_comb begin
        next_state = state;
        err_inc    = 1'b0;
        case (state)
            RESET:    next_state = LOAD_CFG;
            LOAD_CFG: if (update_done) next_state = IDLE;
            IDLE: begin
                if (sop && valid) begin
                    if (bad_beat) begin
                        // A one-beat bad packet is counted and dropped without leaving IDLE.
                        if (eop) err_inc = 1'b1;
                        else     next_state = ERROR;
                    end else if (eop) begin
                        next_state = DRAIN;
                    end else begin
                        next_state = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (bad_beat) begin
                    if (eop) begin
                        err_inc    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = ERROR;
                    end
                end else if (eop) begin
                    next_state = DRAIN;
                end
            end
            DRAIN:    if (drain_cnt == '0) next_state = EVALUATE;
            EVALUATE: next_state = (sum_c >= threshold) ? STORE : IDLE;
            STORE:    next_state = IDLE;
            ERROR: begin
                if (eop) begin
                    err_inc    = 1'b1;
                    next_state = IDLE;
                end
            end
            default:  next_state = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= RESET;
            drain_cnt <= '0;
            ready     <= 1'b0;
            inc_addr  <= 1'b0;
            clear     <= 1'b0;
            score     <= '0;
        end else begin
            state <= next_state;

            if (state != DRAIN && next_state == DRAIN) begin
                drain_cnt <= DRAIN_INIT;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end

            if (state == EVALUATE) begin
                score <= sum_c;
            end

            ready    <= 1'b0;
            inc_addr <= 1'b0;
            clear    <= 1'b0;
            case (next_state)
                IDLE: begin
                    ready <= (empty != '1);
                    clear <= 1'b1;
                end
                COMPARE: ready    <= 1'b1;
                ERROR:   ready    <= 1'b1;
                STORE:   inc_addr <= 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
        sat_counter #(.W(CNT_W)) u_hit (
            .clk   (clk),
            .n_rst (n_rst),
            .inc   (pkt_inc && match[i]),
            .clr   (counter_clear),
            .cnt   (hits[i*CNT_W +: CNT_W])
        );
    end

    sat_counter #(.W(CNT_W)) u_pkt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (pkt_inc),
        .clr   (counter_clear),
        .cnt   (pkt_count)
    );

    sat_counter #(.W(CNT_W)) u_err (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (err_inc),
        .clr   (counter_clear),
        .cnt   (err_count)
    );

endmodule

// File: doc/match_controller_n.md
Name: match_controller_n

Overview:
- Parametrised packet-match controller for the Ethernet sniffer datapath.
- Sequences each packet from the MAC/input FIFO through NUM_CH match comparators (port, IP, MAC, URL, and future channels).
- After a configurable pipeline drain, forms a programmable weighted match score and decides whether to store the packet.
- Keeps per-channel saturating hit counters plus packet and error counters for the Avalon slave to read.

Parameters:
- NUM_CH, 4: number of comparator match channels.
- CNT_W, 64: width of each hit, packet and error counter.
- WEIGHT_W, 4: width of each per-channel weight.
- WAIT_CYCLES, 4: comparator pipeline drain cycles after eop (legal range 1..15).
- ERR_W, 6: MAC error bus width.
- EMPTY_W, 2: input FIFO empty-count width.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- update_done  in  1  comparator reference registers loaded by the Avalon slave.
- sop  in  1  start of packet from MAC.
- eop  in  1  end of packet from MAC.
- valid  in  1  beat valid from MAC.
- error  in  ERR_W  MAC error flags; nonzero means a bad packet.
- empty  in  EMPTY_W  input FIFO empty count.
- match  in  NUM_CH  per-channel comparator match flags.
- weights  in  NUM_CH*WEIGHT_W  channel i weight in bits [i*WEIGHT_W +: WEIGHT_W].
- threshold  in  SUM_W  store threshold, where SUM_W = WEIGHT_W + $clog2(NUM_CH+1).
- counter_clear  in  1  synchronous clear of all counters.
- ready  out  1  input FIFO ready.
- inc_addr  out  1  one-cycle pulse: advance the packet memory address.
- clear  out  1  clear the comparator match flags.
- hits  out  NUM_CH*CNT_W  per-channel hit counters, packed like weights.
- pkt_count  out  CNT_W  packets evaluated.
- err_count  out  CNT_W  packets aborted on error.
- score  out  SUM_W  weighted score of the last evaluated packet.

Behaviour:
- Reset values (async, n_rst=0): state=RESET; all outputs 0, including every counter and score.
- Output registration: all outputs are registered and decoded from next_state. An output therefore reflects the state being entered in the same cycle.
- RESET: go to LOAD_CFG after 1 cycle. Outputs ready=0, clear=0.
- LOAD_CFG: stay until update_done=1, then go to IDLE.
- IDLE:
  - clear=1.
  - ready=1 iff empty != all-ones; otherwise ready=0.
  - On sop&valid with error!=0: go to ERROR. If eop is also 1 in that cycle, increment err_count and stay in IDLE instead.
  - On sop&valid&eop (single-beat packet, no error): go directly to DRAIN.
  - On sop&valid (otherwise): go to COMPARE.
  - sop without valid is ignored.
- COMPARE:
  - ready=1, clear=0.
  - error!=0 has priority over eop.
    - error!=0 with eop=1: increment err_count, go to IDLE.
    - error!=0 with eop=0: go to ERROR.
  - eop=1 with error=0: go to DRAIN and load the drain counter with WAIT_CYCLES-1.
  - sop during COMPARE is ignored.
- DRAIN:
  - ready=0, clear=0.
  - Decrement the drain counter each cycle; go to EVALUATE when it reaches 0.
  - Total DRAIN occupancy is exactly WAIT_CYCLES cycles.
- EVALUATE (1 cycle):
  - Sample match and weights.
  - score = sum over i of (match[i] ? weight_i : 0), computed at SUM_W width so it cannot overflow.
  - Increment hits[i] for each set match[i]; increment pkt_count.
  - Go to STORE if score >= threshold, else go to IDLE.
- STORE (1 cycle): inc_addr=1, ready=0. Go to IDLE. inc_addr is high for exactly one cycle per stored packet.
- ERROR: ready=1 (drain the bad packet). On eop: increment err_count, go to IDLE.
- Counters:
  - All counters saturate at all-ones and never wrap.
  - counter_clear=1 zeroes all counters that cycle. Clear wins over a simultaneous increment.
  - score is not affected by counter_clear.
- Evaluation latency: from the eop cycle, EVALUATE occurs at cycle eop+WAIT_CYCLES+1 and inc_addr at eop+WAIT_CYCLES+2.
- Backpressure: a new sop is accepted only in IDLE. Beats arriving in DRAIN, EVALUATE or STORE are held off by ready=0.
- Reset mid-packet: everything returns to reset values immediately, including counters. The controller re-enters LOAD_CFG and waits for a fresh update_done.

Decomposition:
- Shared package sniffer_pkg holds:
  - the state enum ctrl_state_t (RESET, LOAD_CFG, IDLE, COMPARE, DRAIN, EVALUATE, STORE, ERROR);
  - default parameter constants;
  - the SUM_W calculation function.
- One natural sub-module, sat_counter: parametrised width, with inc and sync clear, where clear has priority and the count saturates. It is instantiated NUM_CH+2 times.

Test Plan:
- Weighted store: weights=1,2,2,4; threshold=4; WAIT_CYCLES=4; 10-beat packet with match=4'b1000 (URL only) → score=4, inc_addr pulses exactly at eop+6, hits[3]=1, pkt_count=1.
- Below threshold: match=4'b0011 (port+IP) → score=3, no inc_addr, hits[0]=hits[1]=1, pkt_count=1, return to IDLE at eop+6.
- Error abort: error=6'h04 mid-packet → ERROR, ready=1 until eop, err_count=1, no hits or pkt_count change. Second case: error and eop in the same beat → IDLE next cycle, err_count=2.
- Single-beat packet: sop&eop&valid in one cycle → DRAIN directly, EVALUATE at +5.
- Backpressure: empty=2'b11 in IDLE → ready=0; empty=2'b10 → ready=1. A packet ending while another sop is offered in DRAIN → ready=0 until IDLE.
- Saturation/clear: CNT_W=4, 17 matching packets → hits=4'hF held. counter_clear asserted on an EVALUATE cycle → counters read 0 the next cycle. n_rst pulsed mid-COMPARE → all outputs 0, state LOAD_CFG after 1 cycle.
